// File: rtl/lbr_unit.sv
// lbr_unit: Last Branch Record storage.
// Captures retired control transfers as {from, to} PC pairs in a circular buffer.
// The buffer is read back through RDLBR (lbrReq=01) and configured through WRLBR (lbrReq=10).
// Optional build macro LBR_FILTER_EN adds a branch_kind input and a per-kind capture mask in control bits [6:4].
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_DISABLED  | no capture; buffer contents retained but not extended
// ST_RECORDING | every qualifying retired transfer is written at wp
// ST_FROZEN    | buffer filled with freeze_on_full set; captures ignored
module lbr_unit #(
    parameter int ADDRESS_BITS = 20,
    parameter int LBR_DEPTH    = 16,
    parameter int INDEX_BITS   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch_valid,
    input  logic [ADDRESS_BITS-1:0] branch_from,
    input  logic [ADDRESS_BITS-1:0] branch_to,
`ifdef LBR_FILTER_EN
    input  logic [1:0]              branch_kind,
`endif
    input  logic [1:0]              lbrReq,
    input  logic [INDEX_BITS-1:0]   lbr_index,
    input  logic                    lbr_sel,
    input  logic [31:0]             lbr_wdata,
    output logic [31:0]             lbr_rdata,
    output logic                    lbr_rvalid,
    output logic [INDEX_BITS:0]     lbr_count,
    output logic                    lbr_full,
    output logic [1:0]              lbr_state
);

    typedef enum logic [1:0] {
        ST_DISABLED  = 2'b00,
        ST_RECORDING = 2'b01,
        ST_FROZEN    = 2'b10
    } state_t;

    localparam int                  ENTRY_BITS = 2 * ADDRESS_BITS;
    localparam logic [INDEX_BITS:0] DEPTH_C    = (INDEX_BITS + 1)'(LBR_DEPTH);

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   wp_q, wp_d;
    logic [INDEX_BITS:0]     count_q, count_d;
    logic                    enable_q, enable_d;
    logic                    freeze_q, freeze_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic [ENTRY_BITS-1:0]   entry_mem [LBR_DEPTH];

    logic                    req_read, req_write;
    logic                    wr_enable, wr_clear, wr_freeze;
    logic                    kind_ok, cap_qual, cap_go;
    logic [INDEX_BITS-1:0]   rd_slot;
    logic [ENTRY_BITS-1:0]   rd_entry;
    logic [ADDRESS_BITS-1:0] rd_field;

    assign req_read  = (lbrReq == 2'b01);
    assign req_write = (lbrReq == 2'b10);
    assign wr_enable = lbr_wdata[0];
    assign wr_clear  = lbr_wdata[1];
    assign wr_freeze = lbr_wdata[2];

`ifdef LBR_FILTER_EN
    logic [2:0] mask_q, mask_d;
    logic       unused_wdata;
    assign unused_wdata = ^{lbr_wdata[31:7], lbr_wdata[3]};
    assign kind_ok = ((branch_kind == 2'b00) && mask_q[0]) ||
                     ((branch_kind == 2'b01) && mask_q[1]) ||
                     ((branch_kind == 2'b10) && mask_q[2]);
`else
    logic unused_wdata;
    assign unused_wdata = ^lbr_wdata[31:3];
    assign kind_ok = 1'b1;
`endif

    // A control write that clears or disables suppresses a same-cycle capture;
    // otherwise the capture proceeds under the pre-write state.
    assign cap_qual = (state_q == ST_RECORDING) && branch_valid && !stall && kind_ok;
    assign cap_go   = cap_qual && !(req_write && (wr_clear || !wr_enable));

    // Read path works on the pre-update pointer/count, so a same-cycle capture is not visible.
    assign rd_slot  = wp_q - INDEX_BITS'(1) - lbr_index;
    assign rd_entry = entry_mem[rd_slot];
    assign rd_field = lbr_sel ? rd_entry[ADDRESS_BITS-1:0] : rd_entry[ENTRY_BITS-1:ADDRESS_BITS];

    // Next-state for pointer, count, control register, FSM and read port.
    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        count_d  = count_q;
        enable_d = enable_q;
        freeze_d = freeze_q;
        rdata_d  = rdata_q;
        rvalid_d = req_read;
`ifdef LBR_FILTER_EN
        mask_d   = mask_q;
`endif

        if (cap_go) begin
            wp_d = wp_q + INDEX_BITS'(1);
            if (count_q != DEPTH_C) begin
                count_d = count_q + (INDEX_BITS + 1)'(1);
            end
        end

        if (req_write) begin
            enable_d = wr_enable;
            freeze_d = wr_freeze;
`ifdef LBR_FILTER_EN
            mask_d   = lbr_wdata[6:4];
`endif
            if (wr_clear) begin
                wp_d    = '0;
                count_d = '0;
            end
            if (!wr_enable) begin
                state_d = ST_DISABLED;
            end else begin
                case (state_q)
                    ST_DISABLED:  state_d = ST_RECORDING;
                    ST_RECORDING: state_d = ST_RECORDING;
                    ST_FROZEN:    state_d = (wr_clear || !wr_freeze) ? ST_RECORDING : ST_FROZEN;
                    default:      state_d = ST_DISABLED;
                endcase
            end
        end

        if ((state_d == ST_RECORDING) && cap_go && (count_d == DEPTH_C) && freeze_d) begin
            state_d = ST_FROZEN;
        end

        if (req_read) begin
            if ({1'b0, lbr_index} >= count_q) begin
                rdata_d = '0;
            end else begin
                rdata_d = {{(32 - ADDRESS_BITS){1'b0}}, rd_field};
            end
        end
    end

    // Control/status registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_DISABLED;
            wp_q     <= '0;
            count_q  <= '0;
            enable_q <= 1'b0;
            freeze_q <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef LBR_FILTER_EN
            mask_q   <= 3'b000;
`endif
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            count_q  <= count_d;
            enable_q <= enable_d;
            freeze_q <= freeze_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef LBR_FILTER_EN
            mask_q   <= mask_d;
`endif
        end
    end

    // Entry storage; deliberately not reset, count gates what is visible.
    always_ff @(posedge clock) begin
        if (cap_go) begin
            entry_mem[wp_q] <= {branch_from, branch_to};
        end
    end

    logic unused_enable;
    assign unused_enable = enable_q;

    assign lbr_rdata  = rdata_q;
    assign lbr_rvalid = rvalid_q;
    assign lbr_count  = count_q;
    assign lbr_full   = (count_q == DEPTH_C);
    assign lbr_state  = state_q;

endmodule

// File: tb/tb_lbr_unit.sv
// Directed testbench for lbr_unit; define LBR_FILTER_EN to build and exercise the kind filter.
module tb_lbr_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_valid;
    logic [19:0] branch_from;
    logic [19:0] branch_to;
    logic [1:0]  branch_kind;
    logic [1:0]  lbrReq;
    logic [3:0]  lbr_index;
    logic        lbr_sel;
    logic [31:0] lbr_wdata;
    logic [31:0] lbr_rdata;
    logic        lbr_rvalid;
    logic [4:0]  lbr_count;
    logic        lbr_full;
    logic [1:0]  lbr_state;

    int checks   = 0;
    int failures = 0;

`ifdef LBR_FILTER_EN
    localparam logic [31:0] MASK_ALL = 32'h70;
`else
    localparam logic [31:0] MASK_ALL = 32'h0;
`endif

    lbr_unit dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_from  (branch_from),
        .branch_to    (branch_to),
`ifdef LBR_FILTER_EN
        .branch_kind  (branch_kind),
`endif
        .lbrReq       (lbrReq),
        .lbr_index    (lbr_index),
        .lbr_sel      (lbr_sel),
        .lbr_wdata    (lbr_wdata),
        .lbr_rdata    (lbr_rdata),
        .lbr_rvalid   (lbr_rvalid),
        .lbr_count    (lbr_count),
        .lbr_full     (lbr_full),
        .lbr_state    (lbr_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [31:0] d);
        lbr_wdata = d | MASK_ALL;
        lbrReq    = 2'b10;
        tick();
        lbrReq    = 2'b00;
    endtask

    task automatic do_capture(input logic [19:0] f, input logic [19:0] t);
        branch_from  = f;
        branch_to    = t;
        branch_valid = 1'b1;
        tick();
        branch_valid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] idx, input logic sel);
        lbr_index = idx;
        lbr_sel   = sel;
        lbrReq    = 2'b01;
        tick();
        lbrReq    = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (lbr_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0h exp=0", lbr_count); end
        checks++; if (lbr_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0h exp=0", lbr_state); end
        checks++; if (lbr_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", lbr_full); end
        checks++; if (lbr_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0h exp=0", lbr_rvalid); end
        do_read(4'd0, 1'b0);
        checks++; if (lbr_rvalid !== 1'b1) begin failures++; $display("FAIL reset_read_rvalid got=%0h exp=1", lbr_rvalid); end
        checks++; if (lbr_rdata !== 32'h0) begin failures++; $display("FAIL reset_read_rdata got=%0h exp=0", lbr_rdata); end
        tick();
        checks++; if (lbr_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%0h exp=0", lbr_rvalid); end
    endtask

    task automatic test_basic();
        do_write(32'h1);
        checks++; if (lbr_state !== 2'b01) begin failures++; $display("FAIL basic_state got=%0h exp=1", lbr_state); end
        do_capture(20'h00100, 20'h00200);
        do_capture(20'h00204, 20'h00040);
        do_read(4'd0, 1'b1);
        checks++; if (lbr_rdata !== 32'h00000040) begin failures++; $display("FAIL basic_idx0_to got=%0h exp=40", lbr_rdata); end
        do_read(4'd1, 1'b0);
        checks++; if (lbr_rdata !== 32'h00000100) begin failures++; $display("FAIL basic_idx1_from got=%0h exp=100", lbr_rdata); end
        checks++; if (lbr_count !== 5'd2) begin failures++; $display("FAIL basic_count got=%0h exp=2", lbr_count); end
        tick();
        checks++; if (lbr_rdata !== 32'h00000100) begin failures++; $display("FAIL rdata_hold got=%0h exp=100", lbr_rdata); end
        do_read(4'd2, 1'b0);
        checks++; if (lbr_rvalid !== 1'b1 || lbr_rdata !== 32'h0) begin failures++; $display("FAIL read_past_count got=%0h/%0h exp=1/0", lbr_rvalid, lbr_rdata); end
    endtask

    task automatic test_wrap();
        do_write(32'h3);
        checks++; if (lbr_count !== 5'd0) begin failures++; $display("FAIL wrap_clear got=%0h exp=0", lbr_count); end
        for (int i = 0; i < 18; i++) begin
            do_capture(20'(i), 20'(i + 32'h1000));
        end
        checks++; if (lbr_count !== 5'd16) begin failures++; $display("FAIL wrap_count got=%0h exp=10", lbr_count); end
        checks++; if (lbr_full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%0h exp=1", lbr_full); end
        checks++; if (lbr_state !== 2'b01) begin failures++; $display("FAIL wrap_state got=%0h exp=1", lbr_state); end
        do_read(4'd0, 1'b0);
        checks++; if (lbr_rdata !== 32'd17) begin failures++; $display("FAIL wrap_idx0 got=%0h exp=11", lbr_rdata); end
        do_read(4'd15, 1'b0);
        checks++; if (lbr_rdata !== 32'd2) begin failures++; $display("FAIL wrap_idx15 got=%0h exp=2", lbr_rdata); end
        do_read(4'd0, 1'b1);
        checks++; if (lbr_rdata !== 32'h1011) begin failures++; $display("FAIL wrap_idx0_to got=%0h exp=1011", lbr_rdata); end
    endtask

    task automatic test_freeze();
        do_write(32'h3);
        do_write(32'h5);
        for (int i = 0; i < 16; i++) begin
            do_capture(20'(32'h300 + i), 20'h0);
        end
        checks++; if (lbr_state !== 2'b10) begin failures++; $display("FAIL freeze_state got=%0h exp=2", lbr_state); end
        do_capture(20'h00ABC, 20'h0);
        checks++; if (lbr_count !== 5'd16) begin failures++; $display("FAIL freeze_count got=%0h exp=10", lbr_count); end
        do_read(4'd0, 1'b0);
        checks++; if (lbr_rdata !== 32'h30F) begin failures++; $display("FAIL freeze_idx0 got=%0h exp=30f", lbr_rdata); end
        do_write(32'h3);
        checks++; if (lbr_count !== 5'd0 || lbr_state !== 2'b01) begin failures++; $display("FAIL unfreeze got=%0h/%0h exp=0/1", lbr_count, lbr_state); end
        checks++; if (lbr_full !== 1'b0) begin failures++; $display("FAIL unfreeze_full got=%0h exp=0", lbr_full); end
    endtask

    task automatic test_stall_and_drop();
        stall = 1'b1;
        do_capture(20'h00500, 20'h00501);
        stall = 1'b0;
        checks++; if (lbr_count !== 5'd0) begin failures++; $display("FAIL stall_count got=%0h exp=0", lbr_count); end
        do_capture(20'h00510, 20'h00511);
        lbr_wdata    = 32'h0 | MASK_ALL;
        lbrReq       = 2'b10;
        branch_from  = 20'h00520;
        branch_to    = 20'h00521;
        branch_valid = 1'b1;
        tick();
        lbrReq       = 2'b00;
        branch_valid = 1'b0;
        checks++; if (lbr_count !== 5'd1) begin failures++; $display("FAIL drop_count got=%0h exp=1", lbr_count); end
        checks++; if (lbr_state !== 2'b00) begin failures++; $display("FAIL drop_state got=%0h exp=0", lbr_state); end
        do_read(4'd0, 1'b0);
        checks++; if (lbr_rdata !== 32'h510) begin failures++; $display("FAIL drop_idx0 got=%0h exp=510", lbr_rdata); end
    endtask

    task automatic test_back_to_back();
        do_write(32'h1);
        lbr_index    = 4'd0;
        lbr_sel      = 1'b0;
        lbrReq       = 2'b01;
        branch_from  = 20'h00530;
        branch_to    = 20'h00531;
        branch_valid = 1'b1;
        tick();
        lbrReq       = 2'b00;
        branch_valid = 1'b0;
        checks++; if (lbr_rdata !== 32'h510) begin failures++; $display("FAIL rdcap_old_view got=%0h exp=510", lbr_rdata); end
        checks++; if (lbr_count !== 5'd2) begin failures++; $display("FAIL rdcap_count got=%0h exp=2", lbr_count); end
        lbr_wdata    = 32'h1 | MASK_ALL;
        lbrReq       = 2'b10;
        branch_from  = 20'h00540;
        branch_to    = 20'h00541;
        branch_valid = 1'b1;
        tick();
        lbrReq       = 2'b00;
        branch_valid = 1'b0;
        checks++; if (lbr_count !== 5'd3) begin failures++; $display("FAIL wrcap_count got=%0h exp=3", lbr_count); end
        do_read(4'd0, 1'b1);
        checks++; if (lbr_rdata !== 32'h541) begin failures++; $display("FAIL wrcap_idx0 got=%0h exp=541", lbr_rdata); end
        lbrReq = 2'b11;
        tick();
        lbrReq = 2'b00;
        checks++; if (lbr_rvalid !== 1'b0 || lbr_state !== 2'b01) begin failures++; $display("FAIL req11_idle got=%0h/%0h exp=0/1", lbr_rvalid, lbr_state); end
    endtask

    task automatic test_reset_midread();
        lbr_index = 4'd0;
        lbrReq    = 2'b01;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        lbrReq    = 2'b00;
        checks++; if (lbr_rvalid !== 1'b0 || lbr_rdata !== 32'h0) begin failures++; $display("FAIL midread_reset got=%0h/%0h exp=0/0", lbr_rvalid, lbr_rdata); end
        checks++; if (lbr_count !== 5'd0 || lbr_state !== 2'b00) begin failures++; $display("FAIL midread_state got=%0h/%0h exp=0/0", lbr_count, lbr_state); end
    endtask

`ifdef LBR_FILTER_EN
    task automatic test_filter();
        lbr_wdata = 32'h21;
        lbrReq    = 2'b10;
        tick();
        lbrReq    = 2'b00;
        branch_kind = 2'b00;
        do_capture(20'h00700, 20'h00701);
        checks++; if (lbr_count !== 5'd0) begin failures++; $display("FAIL filter_cond_drop got=%0h exp=0", lbr_count); end
        branch_kind = 2'b01;
        do_capture(20'h00710, 20'h00711);
        checks++; if (lbr_count !== 5'd1) begin failures++; $display("FAIL filter_jal got=%0h exp=1", lbr_count); end
        branch_kind = 2'b10;
        do_capture(20'h00720, 20'h00721);
        checks++; if (lbr_count !== 5'd1) begin failures++; $display("FAIL filter_jalr_drop got=%0h exp=1", lbr_count); end
        branch_kind = 2'b00;
    endtask
`endif

    initial begin
        reset        = 1'b1;
        stall        = 1'b0;
        branch_valid = 1'b0;
        branch_from  = '0;
        branch_to    = '0;
        branch_kind  = 2'b00;
        lbrReq       = 2'b00;
        lbr_index    = '0;
        lbr_sel      = 1'b0;
        lbr_wdata    = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_freeze();
        test_stall_and_drop();
        test_back_to_back();
        test_reset_midread();
`ifdef LBR_FILTER_EN
        test_filter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
